// File: rtl/idma_ar_credit_gate_pkg.sv
// Shared types for the read-side AR credit gate: default AXI4 AR channel layout.
package idma_ar_credit_gate_pkg;

   localparam int unsigned DefAddrWidth = 24;
   localparam int unsigned DefUserWidth = 1;
   localparam int unsigned DefIdWidth   = 1;

   typedef struct packed {
      logic [DefIdWidth-1:0]   id;
      logic [DefAddrWidth-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
      logic                    lock;
      logic [3:0]              cache;
      logic [2:0]              prot;
      logic [3:0]              qos;
      logic [3:0]              region;
      logic [DefUserWidth-1:0] user;
   } ar_chan_t;

endpackage

// File: rtl/idma_beat_credit_counter.sv
// Beat-credit counter: free dataflow-buffer beats, reserved per released AR
// and returned one per drained W beat.
module idma_beat_credit_counter #(
   parameter int unsigned BufferDepth = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               check_i,
   input  logic                               take_i,
   input  logic [$clog2(BufferDepth+1):0]     need_i,
   input  logic                               give_i,
   output logic [$clog2(BufferDepth+1)-1:0]   credits_o,
   output logic                               enough_o
);

   localparam int unsigned CreditWidth = $clog2(BufferDepth+1);
   localparam int unsigned SumWidth    = CreditWidth + 1;

   logic [CreditWidth-1:0] credits_q, credits_d;
   logic [SumWidth-1:0]    sum;

   // Sufficiency looks at the registered count only, so W never reaches AR combinationally.
   assign enough_o  = {1'b0, credits_q} >= need_i;
   assign credits_o = credits_q;

   // Take and give in the same cycle both apply; clamp guards the upper bound.
   always_comb begin
      sum = {1'b0, credits_q} - (take_i ? need_i : '0) + {{CreditWidth{1'b0}}, give_i};
      if (sum > SumWidth'(BufferDepth)) credits_d = CreditWidth'(BufferDepth);
      else                              credits_d = sum[CreditWidth-1:0];
   end

   // Counter register; starts with the whole buffer free.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credits_q <= CreditWidth'(BufferDepth);
      end else begin
         credits_q <= credits_d;
`ifndef SYNTHESIS
         assert (!(give_i && credits_q == CreditWidth'(BufferDepth)))
            else $error("idma_beat_credit_counter: beat returned while credits are full");
         assert (!(check_i && need_i > SumWidth'(BufferDepth)))
            else $error("idma_beat_credit_counter: burst needs more beats than the buffer holds");
`endif
      end
   end

endmodule

// File: rtl/idma_ar_credit_gate.sv
// Holds AR requests until the dataflow buffer has room for the whole read
// burst; strict FIFO order, bypass reads pass without reserving credits.
module idma_ar_credit_gate
   import idma_ar_credit_gate_pkg::*;
#(
   parameter int unsigned NumAxInFlight = 2,
   parameter int unsigned BufferDepth   = 16,
   parameter int unsigned AddrWidth     = 24,
   parameter int unsigned UserWidth     = 1,
   parameter int unsigned AxiIdWidth    = 1,
   parameter bit          PrintFifoInfo = 1'b0,
   parameter type         axi_ar_chan_t = ar_chan_t
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              testmode_i,
   input  axi_ar_chan_t                      ar_req_i,
   input  logic                              ar_bypass_i,
   input  logic                              ar_valid_i,
   output logic                              ar_ready_o,
   output axi_ar_chan_t                      ar_req_o,
   output logic                              ar_valid_o,
   input  logic                              ar_ready_i,
   input  logic                              w_beat_valid_i,
   input  logic                              w_beat_ready_i,
   input  logic                              w_beat_bypass_i,
   output logic [$clog2(BufferDepth+1)-1:0]  credits_o,
   output logic                              busy_o
);

   localparam int unsigned CreditWidth = $clog2(BufferDepth+1);
   localparam int unsigned PtrW        = (NumAxInFlight > 1) ? $clog2(NumAxInFlight) : 1;
   localparam int unsigned CntW        = $clog2(NumAxInFlight+1);
   localparam int unsigned NeedW       = (CreditWidth + 1 > 9) ? CreditWidth + 1 : 9;

   if (PrintFifoInfo) begin : g_print_info
      $info("idma_ar_credit_gate: AR FIFO depth %0d, buffer depth %0d beats",
            NumAxInFlight, BufferDepth);
   end

   if ($bits(axi_ar_chan_t) < AddrWidth + UserWidth + AxiIdWidth + 8) begin : g_cfg_check
      $error("idma_ar_credit_gate: AR channel type narrower than configured widths");
   end

   // AR and its bypass flag share valid/ready/pop, so they live in one entry.
   typedef struct packed {
      logic         bypass;
      axi_ar_chan_t ar;
   } entry_t;

   entry_t            mem_q [NumAxInFlight];
   entry_t            head;
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   cnt_q;
   logic              fifo_full, head_valid, push, pop;

   logic [NeedW-1:0]       need_wide;
   logic [CreditWidth:0]   need;
   logic                   enough, gate_valid, gate_fire, rel;

   logic                   reg_full_q;
   axi_ar_chan_t           reg_data_q;

   logic                   unused_testmode;
   assign unused_testmode = testmode_i;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(NumAxInFlight - 1)) ? '0 : p + 1'b1;
   endfunction

   assign fifo_full  = cnt_q == CntW'(NumAxInFlight);
   assign head_valid = cnt_q != '0;
   assign head       = mem_q[rd_ptr_q];
   assign ar_ready_o = ~fifo_full;
   assign push       = ar_valid_i & ~fifo_full;
   assign pop        = gate_fire;

   // FIFO storage; no reset needed since the count qualifies every entry.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= '{bypass: ar_bypass_i, ar: ar_req_i};
   end

   // FIFO pointers and occupancy; a push is never visible before the next cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Beats required by the head; oversize bursts saturate just above capacity so they stall.
   always_comb begin
      need_wide = NeedW'(head.ar.len) + NeedW'(1);
      if (head.bypass)                           need = '0;
      else if (need_wide > NeedW'(BufferDepth))  need = (CreditWidth+1)'(BufferDepth + 1);
      else                                       need = need_wide[CreditWidth:0];
   end

   assign gate_valid = head_valid & enough;
   assign gate_fire  = gate_valid & ~reg_full_q;
   assign rel        = w_beat_valid_i & w_beat_ready_i & ~w_beat_bypass_i;

   idma_beat_credit_counter #(
      .BufferDepth (BufferDepth)
   ) i_credit_counter (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .check_i   (head_valid & ~head.bypass),
      .take_i    (gate_fire),
      .need_i    (need),
      .give_i    (rel),
      .credits_o (credits_o),
      .enough_o  (enough)
   );

   // Fall-through output stage: captures the released AR only if the port stalls.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         reg_full_q <= 1'b0;
         reg_data_q <= '0;
      end else if (!reg_full_q) begin
         if (gate_valid && !ar_ready_i) begin
            reg_full_q <= 1'b1;
            reg_data_q <= head.ar;
         end
      end else if (ar_ready_i) begin
         reg_full_q <= 1'b0;
      end
   end

   assign ar_valid_o = reg_full_q | gate_valid;
   assign ar_req_o   = reg_full_q ? reg_data_q : head.ar;
   assign busy_o     = head_valid | ar_valid_o;

endmodule

// File: tb/tb_idma_ar_credit_gate.sv
// Directed bench for idma_ar_credit_gate (NumAxInFlight=2, BufferDepth=16).
module tb_idma_ar_credit_gate;
   import idma_ar_credit_gate_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       testmode = 1'b0;
   ar_chan_t   ar_in, ar_out;
   logic       ar_byp = 1'b0, ar_vin = 1'b0, ar_rdy_out, ar_vout, ar_rdy_in = 1'b1;
   logic       w_v = 1'b0, w_r = 1'b0, w_b = 1'b0;
   logic [4:0] credits;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   idma_ar_credit_gate dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .testmode_i      (testmode),
      .ar_req_i        (ar_in),
      .ar_bypass_i     (ar_byp),
      .ar_valid_i      (ar_vin),
      .ar_ready_o      (ar_rdy_out),
      .ar_req_o        (ar_out),
      .ar_valid_o      (ar_vout),
      .ar_ready_i      (ar_rdy_in),
      .w_beat_valid_i  (w_v),
      .w_beat_ready_i  (w_r),
      .w_beat_bypass_i (w_b),
      .credits_o       (credits),
      .busy_o          (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one AR for a single cycle (caller ensures the FIFO has room).
   task automatic send_ar(input logic [7:0] len, input logic byp);
      ar_in      = '0;
      ar_in.len  = len;
      ar_in.addr = 24'h1000 + {16'd0, len};
      ar_byp     = byp;
      ar_vin     = 1'b1;
      tick();
      ar_vin     = 1'b0;
      ar_byp     = 1'b0;
   endtask

   task automatic give_beats(input int n, input logic byp);
      w_v = 1'b1; w_r = 1'b1; w_b = byp;
      repeat (n) tick();
      w_v = 1'b0; w_r = 1'b0; w_b = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_vec++; if (credits !== 5'd16) begin n_err++; $display("FAIL reset_credits: got %0d want 16", credits); end
      n_vec++; if (ar_vout !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ar_vout); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      n_vec++; if (ar_rdy_out !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ar_rdy_out); end
   endtask

   task automatic test_basic();
      ar_in = '0; ar_in.len = 8'd3; ar_vin = 1'b1;
      @(negedge clk);
      n_vec++; if (ar_vout !== 1'b0) begin n_err++; $display("FAIL basic_no_fallthrough: got %b want 0", ar_vout); end
      tick(); ar_vin = 1'b0;
      @(negedge clk);
      n_vec++; if (ar_vout !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", ar_vout); end
      n_vec++; if (ar_out.len !== 8'd3) begin n_err++; $display("FAIL basic_len: got %0d want 3", ar_out.len); end
      n_vec++; if (credits !== 5'd16) begin n_err++; $display("FAIL basic_pre_credits: got %0d want 16", credits); end
      tick();
      @(negedge clk);
      n_vec++; if (credits !== 5'd12) begin n_err++; $display("FAIL basic_credits: got %0d want 12", credits); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b want 0", busy); end
      give_beats(4, 1'b0);
      @(negedge clk);
      n_vec++; if (credits !== 5'd16) begin n_err++; $display("FAIL basic_return: got %0d want 16", credits); end
   endtask

   task automatic test_starvation();
      send_ar(8'd15, 1'b0);
      send_ar(8'd0, 1'b0);
      @(negedge clk);
      n_vec++; if (credits !== 5'd0) begin n_err++; $display("FAIL starve_credits: got %0d want 0", credits); end
      n_vec++; if (ar_vout !== 1'b0) begin n_err++; $display("FAIL starve_stall: got %b want 0", ar_vout); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL starve_busy: got %b want 1", busy); end
      tick(); tick();
      @(negedge clk);
      n_vec++; if (ar_vout !== 1'b0) begin n_err++; $display("FAIL starve_hold: got %b want 0", ar_vout); end
      give_beats(1, 1'b0);
      @(negedge clk);
      n_vec++; if (credits !== 5'd1) begin n_err++; $display("FAIL starve_one: got %0d want 1", credits); end
      n_vec++; if (ar_vout !== 1'b1) begin n_err++; $display("FAIL starve_release: got %b want 1", ar_vout); end
      tick();
      @(negedge clk);
      n_vec++; if (credits !== 5'd0) begin n_err++; $display("FAIL starve_after: got %0d want 0", credits); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL starve_idle: got %b want 0", busy); end
      give_beats(16, 1'b0);
   endtask

   task automatic test_simultaneous();
      send_ar(8'd11, 1'b0);
      tick();
      @(negedge clk);
      n_vec++; if (credits !== 5'd4) begin n_err++; $display("FAIL simul_pre: got %0d want 4", credits); end
      send_ar(8'd3, 1'b0);
      w_v = 1'b1; w_r = 1'b1; w_b = 1'b0;
      tick();
      w_v = 1'b0; w_r = 1'b0;
      @(negedge clk);
      n_vec++; if (credits !== 5'd1) begin n_err++; $display("FAIL simul_credits: got %0d want 1", credits); end
      give_beats(15, 1'b0);
      @(negedge clk);
      n_vec++; if (credits !== 5'd16) begin n_err++; $display("FAIL simul_return: got %0d want 16", credits); end
   endtask

   task automatic test_bypass();
      send_ar(8'd15, 1'b0);
      tick();
      send_ar(8'd7, 1'b1);
      @(negedge clk);
      n_vec++; if (credits !== 5'd0) begin n_err++; $display("FAIL bypass_zero: got %0d want 0", credits); end
      n_vec++; if (ar_vout !== 1'b1) begin n_err++; $display("FAIL bypass_release: got %b want 1", ar_vout); end
      n_vec++; if (ar_out.len !== 8'd7) begin n_err++; $display("FAIL bypass_len: got %0d want 7", ar_out.len); end
      tick();
      @(negedge clk);
      n_vec++; if (credits !== 5'd0) begin n_err++; $display("FAIL bypass_no_take: got %0d want 0", credits); end
      give_beats(3, 1'b1);
      @(negedge clk);
      n_vec++; if (credits !== 5'd0) begin n_err++; $display("FAIL bypass_beats: got %0d want 0", credits); end
      give_beats(16, 1'b0);
   endtask

   task automatic test_ordering();
      send_ar(8'd15, 1'b0);
      send_ar(8'd3, 1'b0);
      send_ar(8'd5, 1'b1);
      @(negedge clk);
      n_vec++; if (ar_vout !== 1'b0) begin n_err++; $display("FAIL order_no_overtake: got %b want 0", ar_vout); end
      n_vec++; if (ar_rdy_out !== 1'b0) begin n_err++; $display("FAIL order_full: got %b want 0", ar_rdy_out); end
      tick(); tick();
      @(negedge clk);
      n_vec++; if (ar_vout !== 1'b0) begin n_err++; $display("FAIL order_hold: got %b want 0", ar_vout); end
      give_beats(4, 1'b0);
      @(negedge clk);
      n_vec++; if (ar_out.len !== 8'd3 || ar_vout !== 1'b1) begin n_err++; $display("FAIL order_first: got len %0d v %b want len 3 v 1", ar_out.len, ar_vout); end
      tick();
      @(negedge clk);
      n_vec++; if (ar_out.len !== 8'd5 || ar_vout !== 1'b1) begin n_err++; $display("FAIL order_second: got len %0d v %b want len 5 v 1", ar_out.len, ar_vout); end
      tick();
      @(negedge clk);
      n_vec++; if (credits !== 5'd0 || busy !== 1'b0) begin n_err++; $display("FAIL order_done: got credits %0d busy %b want 0 0", credits, busy); end
      give_beats(16, 1'b0);
   endtask

   task automatic test_backpressure();
      ar_rdy_in = 1'b0;
      send_ar(8'd2, 1'b0);
      send_ar(8'd4, 1'b0);
      send_ar(8'd6, 1'b0);
      @(negedge clk);
      n_vec++; if (ar_rdy_out !== 1'b0) begin n_err++; $display("FAIL bp_full: got %b want 0", ar_rdy_out); end
      n_vec++; if (credits !== 5'd13) begin n_err++; $display("FAIL bp_credits: got %0d want 13", credits); end
      ar_in = '0; ar_in.len = 8'd9; ar_vin = 1'b1;
      tick(); ar_vin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_vec++; if (ar_vout !== 1'b1 || ar_out.len !== 8'd2) begin n_err++; $display("FAIL bp_stable%0d: got v %b len %0d want v 1 len 2", i, ar_vout, ar_out.len); end
         tick();
      end
      ar_rdy_in = 1'b1;
      tick(); tick(); tick();
      @(negedge clk);
      n_vec++; if (credits !== 5'd1) begin n_err++; $display("FAIL bp_drain: got %0d want 1", credits); end
      n_vec++; if (busy !== 1'b0 || ar_rdy_out !== 1'b1) begin n_err++; $display("FAIL bp_idle: got busy %b rdy %b want 0 1", busy, ar_rdy_out); end
      give_beats(15, 1'b0);
   endtask

   task automatic test_mid_reset();
      send_ar(8'd10, 1'b0);
      send_ar(8'd12, 1'b0);
      @(negedge clk);
      n_vec++; if (credits !== 5'd5 || busy !== 1'b1) begin n_err++; $display("FAIL mrst_pre: got credits %0d busy %b want 5 1", credits, busy); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (credits !== 5'd16) begin n_err++; $display("FAIL mrst_credits: got %0d want 16", credits); end
      n_vec++; if (ar_vout !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mrst_state: got v %b busy %b want 0 0", ar_vout, busy); end
      #2 rst_n = 1'b1;
      tick();
      @(negedge clk);
      n_vec++; if (ar_rdy_out !== 1'b1 || busy !== 1'b0 || credits !== 5'd16) begin n_err++; $display("FAIL mrst_after: got rdy %b busy %b credits %0d want 1 0 16", ar_rdy_out, busy, credits); end
   endtask

   initial begin
      ar_in = '0;
      test_reset();
      test_basic();
      test_starvation();
      test_simultaneous();
      test_bypass();
      test_ordering();
      test_backpressure();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
